id_exe_reg: RTL and testbench

- Pipeline register between the decode stage (register-file read, control decode) and the execute stage of the ARM pipeline.
- Captures decoded control, operand values and instruction fields on each rising clk edge.
- Supports flush (branch taken) and freeze (hazard stall).
- While frozen or loading, it snoops the write-back port so held operand values stay coherent with register-file writes.

---
 rtl/id_exe_reg.sv | 122 ++++++++++++
 tb/tb_id_exe_reg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register for the ARM pipeline: flush, freeze (stall) and a
// write-back snoop that keeps held or loading operand values coherent.
module id_exe_reg #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 4,
    parameter int PC_INDEX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        status_in,
    input  logic              writeBackEn,
    input  logic [REG_W-1:0]  Dest_wb,
    input  logic [DATA_W-1:0] Result_WB,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic              imm_out,
    output logic [3:0]        exe_cmd_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        status_out
);
    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_INDEX);

    // Index 0 is the rn operand path, index 1 the rm operand path.
    logic [REG_W-1:0]  src_in_arr   [2];
    logic [REG_W-1:0]  src_held_arr [2];
    logic [DATA_W-1:0] val_in_arr   [2];
    logic [DATA_W-1:0] val_held_arr [2];
    logic [DATA_W-1:0] val_next     [2];
    logic [REG_W-1:0]  snoop_idx    [2];
    logic              snoop_hit    [2];

    assign src_in_arr[0]   = src1_in;
    assign src_in_arr[1]   = src2_in;
    assign src_held_arr[0] = src1_out;
    assign src_held_arr[1] = src2_out;
    assign val_in_arr[0]   = val_rn_in;
    assign val_in_arr[1]   = val_rm_in;
    assign val_held_arr[0] = val_rn_out;
    assign val_held_arr[1] = val_rm_out;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_snoop
            // A held bubble carries no real operands, so it never snoops.
            assign snoop_idx[gi] = freeze ? src_held_arr[gi] : src_in_arr[gi];
            assign snoop_hit[gi] = writeBackEn && (Dest_wb != PC_IDX) &&
                                   (Dest_wb == snoop_idx[gi]) && (!freeze || valid_out);
            assign val_next[gi]  = snoop_hit[gi] ? Result_WB :
                                   (freeze ? val_held_arr[gi] : val_in_arr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_out         <= 1'b0;
            pc_out            <= '0;
            wb_en_out         <= 1'b0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            imm_out           <= 1'b0;
            exe_cmd_out       <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            dest_out          <= '0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            status_out        <= '0;
        end else begin
            val_rn_out <= val_next[0];
            val_rm_out <= val_next[1];
            if (!freeze) begin
                valid_out         <= valid_in;
                pc_out            <= pc_in;
                wb_en_out         <= wb_en_in;
                mem_r_en_out      <= mem_r_en_in;
                mem_w_en_out      <= mem_w_en_in;
                b_out             <= b_in;
                s_out             <= s_in;
                imm_out           <= imm_in;
                exe_cmd_out       <= exe_cmd_in;
                src1_out          <= src1_in;
                src2_out          <= src2_in;
                dest_out          <= dest_in;
                shift_operand_out <= shift_operand_in;
                signed_imm_24_out <= signed_imm_24_in;
                status_out        <= status_in;
            end
        end
    end
endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed vector table, hand-written freeze/reset
// sequences and a random run, all checked through an expected-output queue.
module tb_id_exe_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef struct packed {
        logic              rst, flush, freeze, valid;
        logic [DATA_W-1:0] pc;
        logic              wb_en, mem_r, mem_w, b, s, imm;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn, val_rm;
        logic [REG_W-1:0]  src1, src2, dest;
        logic [11:0]       shift;
        logic [23:0]       simm;
        logic [3:0]        status;
        logic              wb_we;
        logic [REG_W-1:0]  wb_dest;
        logic [DATA_W-1:0] wb_res;
    } in_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic              wb_en, mem_r, mem_w, b, s, imm;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn, val_rm;
        logic [REG_W-1:0]  src1, src2, dest;
        logic [11:0]       shift;
        logic [23:0]       simm;
        logic [3:0]        status;
    } out_t;

    typedef struct {
        string             name;
        in_t               in;
        logic              e_valid;
        logic [DATA_W-1:0] e_pc, e_rn, e_rm;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, freeze, valid_in;
    logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in, Result_WB;
    logic              wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]        exe_cmd_in, status_in;
    logic [REG_W-1:0]  src1_in, src2_in, dest_in, Dest_wb;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm_24_in;
    logic              writeBackEn;
    logic              valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]        exe_cmd_out, status_out;
    logic [REG_W-1:0]  src1_out, src2_out, dest_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm_24_out;

    id_exe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .PC_INDEX(15)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .status_in(status_in), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
        .Result_WB(Result_WB), .valid_out(valid_out), .pc_out(pc_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .exe_cmd_out(exe_cmd_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .src1_out(src1_out),
        .src2_out(src2_out), .dest_out(dest_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .status_out(status_out)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    out_t model_state = '0;

    function automatic logic hit(in_t v, logic [REG_W-1:0] idx);
        return v.wb_we && (v.wb_dest != 4'd15) && (v.wb_dest == idx);
    endfunction

    // Reference behaviour: reset/flush clear, freeze holds (snooping only a
    // valid held entry), load copies with bypass of a same-cycle write-back.
    function automatic out_t model(out_t cur, in_t v);
        out_t n;
        if (v.rst || v.flush) begin
            n = '0;
        end else if (v.freeze) begin
            n = cur;
            if (cur.valid && hit(v, cur.src1)) n.val_rn = v.wb_res;
            if (cur.valid && hit(v, cur.src2)) n.val_rm = v.wb_res;
        end else begin
            n = '{valid: v.valid, pc: v.pc, wb_en: v.wb_en, mem_r: v.mem_r, mem_w: v.mem_w,
                  b: v.b, s: v.s, imm: v.imm, exe_cmd: v.exe_cmd, val_rn: v.val_rn,
                  val_rm: v.val_rm, src1: v.src1, src2: v.src2, dest: v.dest,
                  shift: v.shift, simm: v.simm, status: v.status};
            if (hit(v, v.src1)) n.val_rn = v.wb_res;
            if (hit(v, v.src2)) n.val_rm = v.wb_res;
        end
        return n;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = '{valid: valid_out, pc: pc_out, wb_en: wb_en_out, mem_r: mem_r_en_out,
              mem_w: mem_w_en_out, b: b_out, s: s_out, imm: imm_out, exe_cmd: exe_cmd_out,
              val_rn: val_rn_out, val_rm: val_rm_out, src1: src1_out, src2: src2_out,
              dest: dest_out, shift: shift_operand_out, simm: signed_imm_24_out,
              status: status_out};
        return o;
    endfunction

    task automatic check32(string name, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive on the falling edge, push expectation, compare 1 after the rising edge.
    task automatic apply(string name, in_t v);
        out_t got, exp;
        @(negedge clk);
        {rst, flush, freeze, valid_in} = {v.rst, v.flush, v.freeze, v.valid};
        pc_in = v.pc;
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} =
            {v.wb_en, v.mem_r, v.mem_w, v.b, v.s, v.imm};
        exe_cmd_in = v.exe_cmd; val_rn_in = v.val_rn; val_rm_in = v.val_rm;
        src1_in = v.src1; src2_in = v.src2; dest_in = v.dest;
        shift_operand_in = v.shift; signed_imm_24_in = v.simm; status_in = v.status;
        writeBackEn = v.wb_we; Dest_wb = v.wb_dest; Result_WB = v.wb_res;
        model_state = model(model_state, v);
        exp_q.push_back(model_state);
        @(posedge clk);
        #1;
        got = sample();
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("vec %s: out=%h", name, got);
        end
    endtask

    function automatic in_t load(logic [DATA_W-1:0] pc, logic [DATA_W-1:0] rn,
                                 logic [DATA_W-1:0] rm, logic [3:0] s1, logic [3:0] s2);
        in_t v = '0;
        v.valid = 1'b1; v.pc = pc; v.val_rn = rn; v.val_rm = rm; v.src1 = s1; v.src2 = s2;
        v.exe_cmd = 4'd1; v.dest = 4'd2; v.shift = 12'h5A5; v.simm = 24'h123456; v.status = 4'h9;
        return v;
    endfunction

    function automatic in_t with_wb(in_t v, logic [3:0] d, logic [DATA_W-1:0] r);
        in_t w = v;
        w.wb_we = 1'b1; w.wb_dest = d; w.wb_res = r;
        return w;
    endfunction

    vec_t tbl[10];
    in_t  v;
    out_t snap;

    initial begin
        // Reset with every input driven non-zero.
        v = '1;
        tbl[0] = '{"reset_all_ones", v, 1'b0, 32'h0, 32'h0, 32'h0};
        v = load(32'h10, 32'h11, 32'h22, 4'd0, 4'd1); v.exe_cmd = 4'b0010;
        tbl[1] = '{"first_load", v, 1'b1, 32'h10, 32'h11, 32'h22};
        v = with_wb(load(32'h14, 32'hAAAA0000, 32'hBBBB, 4'd3, 4'd5), 4'd3, 32'h12345678);
        tbl[2] = '{"load_bypass_rn", v, 1'b1, 32'h14, 32'h12345678, 32'hBBBB};
        v = with_wb(load(32'h18, 32'h99, 32'h98, 4'd15, 4'd15), 4'd15, 32'h55);
        tbl[3] = '{"pc_index_nomatch", v, 1'b1, 32'h18, 32'h99, 32'h98};
        v = with_wb(load(32'h1C, 32'h1, 32'h2, 4'd9, 4'd9), 4'd9, 32'h77);
        tbl[4] = '{"same_src_bypass", v, 1'b1, 32'h1C, 32'h77, 32'h77};
        v = load(32'h20, 32'h1, 32'h2, 4'd9, 4'd9); v.wb_dest = 4'd9; v.wb_res = 32'h77;
        tbl[5] = '{"same_src_we0", v, 1'b1, 32'h20, 32'h1, 32'h2};
        v = load(32'h40, 32'h3, 32'h4, 4'd1, 4'd2); v.wb_en = 1'b1; v.b = 1'b1;
        tbl[6] = '{"load_wb_b", v, 1'b1, 32'h40, 32'h3, 32'h4};
        v = load(32'h44, 32'h5, 32'h6, 4'd1, 4'd2); v.flush = 1'b1; v.freeze = 1'b1;
        tbl[7] = '{"flush_over_freeze", v, 1'b0, 32'h0, 32'h0, 32'h0};
        v = load(32'h50, 32'h3, 32'h4, 4'd1, 4'd2);
        tbl[8] = '{"resume_after_flush", v, 1'b1, 32'h50, 32'h3, 32'h4};
        v = load(32'h60, 32'h7, 32'h8, 4'd6, 4'd6); v.valid = 1'b0;
        tbl[9] = '{"bubble_load", v, 1'b0, 32'h60, 32'h7, 32'h8};

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].name, tbl[i].in);
            check32({tbl[i].name, ".valid"}, {31'b0, valid_out}, {31'b0, tbl[i].e_valid});
            check32({tbl[i].name, ".pc"}, pc_out, tbl[i].e_pc);
            check32({tbl[i].name, ".rn"}, val_rn_out, tbl[i].e_rn);
            check32({tbl[i].name, ".rm"}, val_rm_out, tbl[i].e_rm);
        end
        check32("flush_over_freeze.ctrl", {30'b0, wb_en_out, b_out}, 32'h0);

        // Held bubble must not snoop.
        v = '1; v.rst = 1'b0; v.flush = 1'b0; v.freeze = 1'b1;
        v.wb_we = 1'b1; v.wb_dest = 4'd6; v.wb_res = 32'hCAFE;
        apply("freeze_bubble_nosnoop", v);
        check32("freeze_bubble_nosnoop.rn", val_rn_out, 32'h7);

        // Freeze for 3 cycles with a matching write-back in the second.
        apply("load_src2_7", load(32'h70, 32'h100, 32'h1, 4'd4, 4'd7));
        snap = sample();
        v = load(32'hFFFF, 32'hEEEE, 32'hDDDD, 4'd3, 4'd3); v.freeze = 1'b1; v.exe_cmd = 4'hF;
        apply("freeze_c1", v);
        check32("freeze_c1.rm", val_rm_out, 32'h1);
        apply("freeze_c2_wb", with_wb(v, 4'd7, 32'hDEADBEEF));
        check32("freeze_c2.rm", val_rm_out, 32'hDEADBEEF);
        apply("freeze_c3", v);
        check32("freeze_c3.rm", val_rm_out, 32'hDEADBEEF);
        check32("freeze_c3.pc", pc_out, snap.pc);
        check32("freeze_c3.rn", val_rn_out, snap.val_rn);

        // Reset in the middle of a freeze, then freeze alone keeps the clear state.
        v.rst = 1'b1;
        apply("reset_mid_freeze", v);
        check32("reset_mid_freeze.pc", pc_out, 32'h0);
        v.rst = 1'b0;
        apply("freeze_after_reset", with_wb(v, 4'd3, 32'h4242));
        check32("freeze_after_reset.valid", {31'b0, valid_out}, 32'h0);
        check32("freeze_after_reset.rn", val_rn_out, 32'h0);

        // Random traffic with small register indices so snoops collide often.
        for (int i = 0; i < 300; i++) begin
            v = '0;
            v.rst = ($urandom_range(0, 29) == 0);
            v.flush = ($urandom_range(0, 11) == 0);
            v.freeze = ($urandom_range(0, 2) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.pc = $urandom;
            {v.wb_en, v.mem_r, v.mem_w, v.b, v.s, v.imm} = 6'($urandom);
            v.exe_cmd = 4'($urandom); v.val_rn = $urandom; v.val_rm = $urandom;
            v.src1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.src2 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.dest = 4'($urandom); v.shift = 12'($urandom); v.simm = 24'($urandom);
            v.status = 4'($urandom); v.wb_we = 1'($urandom);
            v.wb_dest = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.wb_res = $urandom;
            apply($sformatf("rand%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
